ddr_arrow_renderer: RTL and testbench

Downstream consumer of `hvsync_generator`: takes the raster position (`CounterX`, `CounterY`, `inDisplayArea`) and the active-low `vga_v_sync`, and holds up to 16 scrolling arrow notes (4 lanes × 4 slots). It moves the notes once per frame, judges player hit requests against a target bar, and produces the registered 1-bit-per-colour VGA pixel stream.

---
 rtl/ddr_arrow_renderer.sv | 223 ++++++++++++++++++++++
 tb/tb_ddr_arrow_renderer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arrow_renderer.sv
// Four-lane scrolling-arrow playfield. Moves the notes once per frame, judges
// hits and misses, and drives a registered 1-bit-per-colour pixel stream.
`timescale 1ns/1ps
module ddr_arrow_renderer #(
    parameter logic [8:0] SPAWN_Y  = 9'd464,
    parameter logic [8:0] TARGET_Y = 9'd40,
    parameter logic [8:0] WINDOW   = 9'd8,
    parameter logic [8:0] SCROLL   = 9'd2,
    parameter logic [8:0] ARROW_H  = 9'd16,
    parameter logic [9:0] LANE_X0  = 10'd192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] CounterX,
    input  logic [8:0] CounterY,
    input  logic       inDisplayArea,
    input  logic       vga_v_sync,
    input  logic       spawn_valid,
    input  logic [1:0] spawn_lane,
    output logic       spawn_ready,
    input  logic [3:0] hit_req,
    output logic [3:0] hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b
);

    localparam logic [8:0] WIN_LO_Y   = TARGET_Y - WINDOW;
    localparam logic [8:0] WIN_HI_Y   = TARGET_Y + WINDOW;
    localparam logic [9:0] MISS_THR_Y = {1'b0, TARGET_Y} - {1'b0, WINDOW} + {1'b0, SCROLL};
    localparam logic [9:0] LANE_W     = 10'd48;

    logic [15:0]      valid_r;
    logic [15:0][8:0] y_r;
    logic             vsync_r;
    logic             armed_r;
    logic             frame_upd_r;
    logic [3:0]       hit_pulse_r;
    logic             miss_pulse_r;
    logic [7:0]       hit_count_r;
    logic [7:0]       miss_count_r;
    logic [2:0]       rgb_r;

    logic [15:0]      hit_clr_s;
    logic [3:0]       hit_succ_s;
    logic [3:0]       lane_free_s;
    logic [3:0]       spawn_idx_s;
    logic             spawn_ready_s;
    logic             spawn_acc_s;
    logic [15:0]      valid_n_s;
    logic [15:0][8:0] y_n_s;
    logic [4:0]       miss_sum_s;
    logic [2:0]       pix_n_s;

    function automatic logic [2:0] lane_rgb(input logic [1:0] lane);
        logic [2:0] rgb;
        case (lane)
            2'd0:    rgb = 3'b100;
            2'd1:    rgb = 3'b001;
            2'd2:    rgb = 3'b010;
            2'd3:    rgb = 3'b110;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [4:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {4'b0000, inc};
        return (sum > 9'd255) ? 8'd255 : sum[7:0];
    endfunction

    // Per-lane hit selection: smallest in-window y wins, lowest index on a tie.
    always_comb begin
        logic       found;
        logic       take;
        logic [8:0] best_y;
        logic [3:0] best_i;
        logic [3:0] idx;
        hit_clr_s  = 16'd0;
        hit_succ_s = 4'd0;
        found  = 1'b0;
        take   = 1'b0;
        best_y = 9'd0;
        best_i = 4'd0;
        idx    = 4'd0;
        for (int l = 0; l < 4; l++) begin
            found  = 1'b0;
            best_y = 9'd0;
            best_i = 4'(l * 4);
            for (int s = 0; s < 4; s++) begin
                idx  = 4'(l * 4 + s);
                take = hit_req[l] & valid_r[idx] & (y_r[idx] >= WIN_LO_Y) &
                       (y_r[idx] <= WIN_HI_Y) & (~found | (y_r[idx] < best_y));
                best_y = take ? y_r[idx] : best_y;
                best_i = take ? idx : best_i;
                found  = found | take;
            end
            hit_clr_s[best_i] = found;
            hit_succ_s[l]     = found;
        end
    end

    // Spawn acceptance and lowest free slot of the requested lane.
    always_comb begin
        lane_free_s = ~valid_r[{spawn_lane, 2'b00} +: 4];
        spawn_idx_s = {spawn_lane, 2'b00};
        for (int s = 3; s >= 0; s--) begin
            spawn_idx_s = lane_free_s[s] ? {spawn_lane, 2'(s)} : spawn_idx_s;
        end
        spawn_ready_s = ~frame_upd_r & (|lane_free_s);
        spawn_acc_s   = spawn_valid & spawn_ready_s;
    end

    assign spawn_ready = spawn_ready_s;

    // Next slot state; a hit-cleared slot is neither moved nor counted as a miss.
    always_comb begin
        valid_n_s  = valid_r;
        y_n_s      = y_r;
        miss_sum_s = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (spawn_acc_s && (spawn_idx_s == 4'(i))) begin
                valid_n_s[i] = 1'b1;
                y_n_s[i]     = SPAWN_Y;
            end else if (hit_clr_s[i]) begin
                valid_n_s[i] = 1'b0;
            end else if (frame_upd_r && valid_r[i]) begin
                if ({1'b0, y_r[i]} < MISS_THR_Y) begin
                    valid_n_s[i] = 1'b0;
                    miss_sum_s   = miss_sum_s + 5'd1;
                end else begin
                    y_n_s[i] = y_r[i] - SCROLL;
                end
            end else begin
                y_n_s[i] = y_r[i];
            end
        end
    end

    // Pixel colour: target bar over arrows over black.
    always_comb begin
        logic [9:0] lane_lo;
        logic       in_lane;
        logic       any_lane;
        logic       arrow_on;
        logic       bar_row;
        logic [2:0] arrow_rgb;
        logic [3:0] idx;
        lane_lo   = 10'd0;
        in_lane   = 1'b0;
        any_lane  = 1'b0;
        arrow_on  = 1'b0;
        arrow_rgb = 3'b000;
        idx       = 4'd0;
        bar_row   = (CounterY == TARGET_Y) || (CounterY == TARGET_Y + 9'd1);
        for (int l = 0; l < 4; l++) begin
            lane_lo  = LANE_X0 + 10'(l * 64);
            in_lane  = (CounterX >= lane_lo) && (CounterX < lane_lo + LANE_W);
            arrow_on = 1'b0;
            for (int s = 0; s < 4; s++) begin
                idx = 4'(l * 4 + s);
                arrow_on = arrow_on | (valid_r[idx] && (CounterY >= y_r[idx]) &&
                           ({1'b0, CounterY} < {1'b0, y_r[idx]} + {1'b0, ARROW_H}));
            end
            any_lane  = any_lane | in_lane;
            arrow_rgb = (in_lane && arrow_on) ? lane_rgb(2'(l)) : arrow_rgb;
        end
        if (!inDisplayArea) begin
            pix_n_s = 3'b000;
        end else if (bar_row && any_lane) begin
            pix_n_s = 3'b111;
        end else begin
            pix_n_s = arrow_rgb;
        end
    end

    // Slot storage and frame tick; a sync level already low at reset release is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r     <= 16'd0;
            y_r         <= {16{9'd0}};
            vsync_r     <= 1'b1;
            armed_r     <= 1'b0;
            frame_upd_r <= 1'b0;
        end else begin
            valid_r     <= valid_n_s;
            y_r         <= y_n_s;
            vsync_r     <= vga_v_sync;
            armed_r     <= armed_r | vga_v_sync;
            frame_upd_r <= armed_r & vsync_r & ~vga_v_sync;
        end
    end

    // Registered pulses, saturating counters and pixel output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_pulse_r  <= 4'd0;
            miss_pulse_r <= 1'b0;
            hit_count_r  <= 8'd0;
            miss_count_r <= 8'd0;
            rgb_r        <= 3'b000;
        end else begin
            hit_pulse_r  <= hit_succ_s;
            miss_pulse_r <= (miss_sum_s != 5'd0);
            hit_count_r  <= sat_add8(hit_count_r, {2'b00, 3'($countones(hit_succ_s))});
            miss_count_r <= sat_add8(miss_count_r, miss_sum_s);
            rgb_r        <= pix_n_s;
        end
    end

    assign hit_pulse  = hit_pulse_r;
    assign miss_pulse = miss_pulse_r;
    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
    assign vga_r      = rgb_r[2];
    assign vga_g      = rgb_r[1];
    assign vga_b      = rgb_r[0];

endmodule

// File: tb/tb_ddr_arrow_renderer.sv
// Self-checking bench for ddr_arrow_renderer: pixel tables, directed hit/miss
// sequences and random traffic compared with a cycle-level playfield model.
`timescale 1ns/1ps
module tb_ddr_arrow_renderer;

    logic       clk_tb = 1'b0;
    logic       reset;
    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       inDisplayArea;
    logic       vga_v_sync;
    logic       spawn_valid;
    logic [1:0] spawn_lane;
    logic       spawn_ready;
    logic [3:0] hit_req;
    logic [3:0] hit_pulse;
    logic       miss_pulse;
    logic [7:0] hit_count;
    logic [7:0] miss_count;
    logic       vga_r, vga_g, vga_b;

    ddr_arrow_renderer dut (
        .clk(clk_tb), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
        .inDisplayArea(inDisplayArea), .vga_v_sync(vga_v_sync),
        .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
        .hit_req(hit_req), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .hit_count(hit_count), .miss_count(miss_count),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk_tb = ~clk_tb;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       disp;
        logic [2:0] rgb;
    } pix_vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Playfield model: 4 lanes x 4 slots, slot i belongs to lane i/4.
    bit m_valid[16];
    int m_y[16];
    bit m_vs, m_armed, m_fu;
    int m_hit, m_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void reset_model();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_y[i]     = 0;
        end
        m_vs = 1'b1; m_armed = 1'b0; m_fu = 1'b0;
        m_hit = 0; m_miss = 0;
    endfunction

    function automatic logic [2:0] pixel_model(input int x, input int y, input bit disp);
        int lane, off;
        if (!disp || x < 192) return 3'b000;
        lane = (x - 192) / 64;
        off  = (x - 192) % 64;
        if (lane > 3 || off >= 48) return 3'b000;
        if (y == 40 || y == 41) return 3'b111;
        for (int s = 0; s < 4; s++) begin
            if (m_valid[lane*4+s] && y >= m_y[lane*4+s] && y < m_y[lane*4+s] + 16) begin
                case (lane)
                    0: return 3'b100;
                    1: return 3'b001;
                    2: return 3'b010;
                    default: return 3'b110;
                endcase
            end
        end
        return 3'b000;
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // One clock: predict from current inputs and model, clock, compare outputs.
    task automatic step();
        bit full, exp_ready;
        bit clr[16];
        bit nv[16];
        int ny[16];
        logic [3:0] hp;
        logic [2:0] exp_rgb;
        int misses, best, base;
        bit nfu;
        #1;
        base = int'(spawn_lane) * 4;
        full = 1'b1;
        for (int s = 0; s < 4; s++) if (!m_valid[base+s]) full = 1'b0;
        exp_ready = !m_fu && !full;
        check("spawn_ready", spawn_ready, exp_ready);
        exp_rgb = pixel_model(int'(CounterX), int'(CounterY), inDisplayArea);
        nv = m_valid; ny = m_y; hp = 4'd0; misses = 0;
        for (int i = 0; i < 16; i++) clr[i] = 1'b0;
        for (int l = 0; l < 4; l++) begin
            if (hit_req[l]) begin
                best = -1;
                for (int s = 0; s < 4; s++) begin
                    if (m_valid[l*4+s] && m_y[l*4+s] >= 32 && m_y[l*4+s] <= 48 &&
                        (best < 0 || m_y[l*4+s] < m_y[best])) best = l*4+s;
                end
                if (best >= 0) begin
                    nv[best] = 1'b0; clr[best] = 1'b1; hp[l] = 1'b1;
                end
            end
        end
        if (m_fu) begin
            for (int i = 0; i < 16; i++) begin
                if (m_valid[i] && !clr[i]) begin
                    if (m_y[i] < 34) begin
                        nv[i] = 1'b0; misses++;
                    end else begin
                        ny[i] = m_y[i] - 2;
                    end
                end
            end
        end
        if (spawn_valid && exp_ready) begin
            for (int s = 0; s < 4; s++) begin
                if (!m_valid[base+s]) begin
                    nv[base+s] = 1'b1; ny[base+s] = 464;
                    break;
                end
            end
        end
        m_hit  = sat255(m_hit + $countones(hp));
        m_miss = sat255(m_miss + misses);
        nfu = m_armed && m_vs && !vga_v_sync;
        m_armed = m_armed || vga_v_sync;
        m_vs = vga_v_sync;
        @(posedge clk_tb);
        #1;
        m_valid = nv; m_y = ny; m_fu = nfu;
        check("hit_pulse", hit_pulse, hp);
        check("miss_pulse", miss_pulse, (misses > 0));
        check("hit_count", hit_count, m_hit);
        check("miss_count", miss_count, m_miss);
        check("pixel", {vga_r, vga_g, vga_b}, exp_rgb);
    endtask

    task automatic cyc(input bit sv, input logic [1:0] sl, input logic [3:0] hr, input logic vs);
        spawn_valid = sv; spawn_lane = sl; hit_req = hr; vga_v_sync = vs;
        step();
    endtask

    task automatic frame();
        cyc(1'b0, 2'd0, 4'd0, 1'b0);
        cyc(1'b0, 2'd0, 4'd0, 1'b1);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic set_pix(input int x, input int y, input bit d);
        CounterX = 10'(x); CounterY = 9'(y); inDisplayArea = d;
    endtask

    task automatic do_reset(input logic vs_lvl);
        spawn_valid = 1'b0; hit_req = 4'd0; vga_v_sync = vs_lvl;
        #2 reset = 1'b0;
        #1;
        check("rst_hit_pulse", hit_pulse, 4'd0);
        check("rst_miss_pulse", miss_pulse, 1'b0);
        check("rst_hit_count", hit_count, 8'd0);
        check("rst_miss_count", miss_count, 8'd0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 3'b000);
        reset_model();
        @(posedge clk_tb);
        #1 reset = 1'b1;
    endtask

    pix_vec_t bar_tab[10];
    pix_vec_t arrow_tab[6];

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        bar_tab[0] = '{10'd192, 9'd40, 1'b1, 3'b111};
        bar_tab[1] = '{10'd239, 9'd41, 1'b1, 3'b111};
        bar_tab[2] = '{10'd240, 9'd40, 1'b1, 3'b000};
        bar_tab[3] = '{10'd191, 9'd40, 1'b1, 3'b000};
        bar_tab[4] = '{10'd256, 9'd40, 1'b1, 3'b111};
        bar_tab[5] = '{10'd431, 9'd41, 1'b1, 3'b111};
        bar_tab[6] = '{10'd432, 9'd40, 1'b1, 3'b000};
        bar_tab[7] = '{10'd200, 9'd42, 1'b1, 3'b000};
        bar_tab[8] = '{10'd200, 9'd39, 1'b1, 3'b000};
        bar_tab[9] = '{10'd200, 9'd40, 1'b0, 3'b000};
        arrow_tab[0] = '{10'd320, 9'd444, 1'b1, 3'b010};
        arrow_tab[1] = '{10'd367, 9'd459, 1'b1, 3'b010};
        arrow_tab[2] = '{10'd368, 9'd450, 1'b1, 3'b000};
        arrow_tab[3] = '{10'd320, 9'd460, 1'b1, 3'b000};
        arrow_tab[4] = '{10'd320, 9'd443, 1'b1, 3'b000};
        arrow_tab[5] = '{10'd340, 9'd450, 1'b0, 3'b000};

        reset = 1'b0; vga_v_sync = 1'b1; spawn_valid = 1'b0; spawn_lane = 2'd0;
        hit_req = 4'd0; set_pix(0, 0, 1'b0);
        reset_model();
        repeat (2) @(posedge clk_tb);
        #1;
        check("init_rgb", {vga_r, vga_g, vga_b}, 3'b000);
        check("init_counts", {hit_count, miss_count}, 16'd0);
        reset = 1'b1;
        cyc(1'b0, 2'd0, 4'd0, 1'b1);

        // Empty playfield: only the target bar.
        for (int i = 0; i < 10; i++) begin
            set_pix(int'(bar_tab[i].x), int'(bar_tab[i].y), bar_tab[i].disp);
            cyc(1'b0, 2'd0, 4'd0, 1'b1);
            check("bar_tab", {vga_r, vga_g, vga_b}, bar_tab[i].rgb);
        end

        // Lane 2 arrow after 10 frames sits at y=444.
        cyc(1'b1, 2'd2, 4'd0, 1'b1);
        frames(10);
        for (int i = 0; i < 6; i++) begin
            set_pix(int'(arrow_tab[i].x), int'(arrow_tab[i].y), arrow_tab[i].disp);
            cyc(1'b0, 2'd0, 4'd0, 1'b1);
            check("arrow_tab", {vga_r, vga_g, vga_b}, arrow_tab[i].rgb);
        end

        // Lane full, and no spawn during the frame update cycle.
        for (int k = 0; k < 4; k++) cyc(1'b1, 2'd1, 4'd0, 1'b1);
        spawn_valid = 1'b1; spawn_lane = 2'd1; #1;
        check("ready_lane_full", spawn_ready, 1'b0);
        spawn_lane = 2'd3; #1;
        check("ready_other_lane", spawn_ready, 1'b1);
        spawn_lane = 2'd1;
        step();
        cyc(1'b0, 2'd0, 4'd0, 1'b0);
        spawn_valid = 1'b1; spawn_lane = 2'd3; hit_req = 4'd0; vga_v_sync = 1'b1; #1;
        check("ready_in_upd", spawn_ready, 1'b0);
        step();

        // Hit outside, then inside, the window on lane 0.
        do_reset(1'b1);
        cyc(1'b0, 2'd0, 4'd0, 1'b1);
        cyc(1'b1, 2'd0, 4'd0, 1'b1);
        frames(207);
        set_pix(192, 50, 1'b1);
        cyc(1'b0, 2'd0, 4'b0001, 1'b1);
        check("hit_outside_pulse", hit_pulse, 4'd0);
        check("hit_outside_count", hit_count, 8'd0);
        check("hit_outside_pix", {vga_r, vga_g, vga_b}, 3'b100);
        frames(3);
        cyc(1'b0, 2'd0, 4'b0001, 1'b1);
        check("hit_in_pulse", hit_pulse, 4'b0001);
        check("hit_in_count", hit_count, 8'd1);
        cyc(1'b0, 2'd0, 4'b0001, 1'b1);
        check("hit_repeat_pulse", hit_pulse, 4'd0);
        check("hit_repeat_count", hit_count, 8'd1);
        check("hit_gone_pix", {vga_r, vga_g, vga_b}, 3'b000);

        // Reset mid-raster on a bar pixel, released with sync already low.
        set_pix(192, 40, 1'b1);
        cyc(1'b0, 2'd0, 4'd0, 1'b1);
        do_reset(1'b0);
        cyc(1'b1, 2'd0, 4'd0, 1'b0);
        set_pix(200, 478, 1'b1);
        for (int k = 0; k < 4; k++) cyc(1'b0, 2'd0, 4'd0, 1'b0);
        check("no_upd_after_rst", {vga_r, vga_g, vga_b}, 3'b100);

        // Single miss, then three lanes expiring together.
        do_reset(1'b1);
        cyc(1'b0, 2'd0, 4'd0, 1'b1);
        cyc(1'b1, 2'd3, 4'd0, 1'b1);
        frames(216);
        check("miss_before", miss_count, 8'd0);
        frame();
        check("miss_pulse_1", miss_pulse, 1'b1);
        check("miss_count_1", miss_count, 8'd1);
        cyc(1'b0, 2'd0, 4'd0, 1'b1);
        check("miss_pulse_off", miss_pulse, 1'b0);
        for (int l = 0; l < 3; l++) cyc(1'b1, 2'(l), 4'd0, 1'b1);
        frames(216);
        check("miss3_before", miss_count, 8'd1);
        frame();
        check("miss3_pulse", miss_pulse, 1'b1);
        check("miss3_count", miss_count, 8'd4);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int pick;
            pick = int'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 0) begin
                set_pix(192 + 64 * (pick / 4) + int'($urandom_range(49, 0)),
                        m_y[pick] + int'($urandom_range(17, 0)) - 1,
                        $urandom_range(7, 0) != 0);
            end else begin
                set_pix(int'($urandom_range(700, 0)), int'($urandom_range(511, 0)),
                        $urandom_range(7, 0) != 0);
            end
            cyc($urandom_range(2, 0) == 0, 2'($urandom_range(3, 0)),
                ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'd0,
                $urandom_range(5, 0) != 0);
        end

        // Miss counter saturation.
        do_reset(1'b1);
        set_pix(0, 0, 1'b0);
        cyc(1'b0, 2'd0, 4'd0, 1'b1);
        for (int f = 0; f < 4500; f++) begin
            cyc(1'b1, 2'(f % 4), 4'd0, 1'b0);
            cyc(1'b0, 2'd0, 4'd0, 1'b1);
        end
        check("miss_saturate", miss_count, 8'd255);

        // Hit counter saturation.
        do_reset(1'b1);
        cyc(1'b0, 2'd0, 4'd0, 1'b1);
        for (int f = 0; f < 4500; f++) begin
            cyc(1'b1, 2'(f % 4), 4'hF, 1'b0);
            cyc(1'b0, 2'd0, 4'hF, 1'b1);
        end
        check("hit_saturate", hit_count, 8'd255);
        check("hit_sat_no_miss", miss_count, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
